// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
// The PARITY state is always part of the enum; whether it is reachable is
// decided by FIFO_UART_TX_PARITY_EN in fifo_uart_tx.
package fifo_uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// Modulo-CLKS_PER_BIT counter.
// Counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count.
// A synchronous clear restarts the count at 0.
module baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] count;

    // count up, wrap on terminal count, restart on reset or clear
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Read-side drain stage: pops bytes from the shared FIFO port and sends
// each one as a UART frame on tx, LSB first.
// Build option FIFO_UART_TX_PARITY_EN: adds an even-parity bit (8E1);
// without it the frame is 8N1.
//
// state  | meaning
// IDLE   | line idle, waiting for tx_enable and a non-empty FIFO
// FETCH  | one-cycle pop, byte captured at the closing edge
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | even parity bit (only with FIFO_UART_TX_PARITY_EN)
// STOP   | stop bit (high); may chain straight into the next FETCH
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_enable,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_io,
    output logic                 fifo_en,
    output logic                 fifo_rw,
    output logic                 tx,
    output logic                 busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t               state;
    state_t               state_next;
    logic                 baud_tick;
    logic                 baud_clear;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 start_ok;

`ifdef FIFO_UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign start_ok   = tx_enable && !fifo_empty;
    assign baud_clear = (state_next != state);

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (baud_tick)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state decode
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                state_next = ST_START;
            end
            ST_START: begin
                if (baud_tick) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (baud_tick && (bit_idx == LAST_BIT)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (baud_tick) state_next = start_ok ? ST_FETCH : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // byte capture on the pop cycle, shift and bit count per data bit
    always_ff @(posedge clk) begin
        if (reset) begin
            shift   <= '0;
            bit_idx <= '0;
        end else if (state == ST_FETCH) begin
            shift   <= fifo_io;
            bit_idx <= '0;
        end else if ((state == ST_DATA) && baud_tick) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    // parity taken from the byte as popped, since the shifter drains to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_bit <= 1'b0;
        end else if (state == ST_FETCH) begin
            parity_bit <= ^fifo_io;
        end
    end
`endif

    // Moore output decode from the registered state
    always_comb begin
        fifo_en = 1'b0;
        tx      = IDLE_LEVEL;
        busy    = 1'b1;
        case (state)
            ST_IDLE:   busy    = 1'b0;
            ST_FETCH:  fifo_en = 1'b1;
            ST_START:  tx      = ~IDLE_LEVEL;
            ST_DATA:   tx      = shift[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx      = parity_bit;
`endif
            default:   tx      = IDLE_LEVEL;
        endcase
    end

    assign fifo_rw = 1'b0;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: a queue stands in for the FIFO, and expected
// line traces are built frame by frame from the byte list.
module tb_fifo_uart_tx;

    localparam int C    = 4;
    localparam int MAXC = 256;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = 1 + FB * C;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_enable;
    logic       fifo_empty;
    logic [7:0] fifo_io;
    logic       fifo_en;
    logic       fifo_rw;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_enable (tx_enable),
        .fifo_empty(fifo_empty),
        .fifo_io   (fifo_io),
        .fifo_en   (fifo_en),
        .fifo_rw   (fifo_rw),
        .tx        (tx),
        .busy      (busy)
    );

    int checks = 0;
    int passed = 0;

    byte unsigned   q[$];
    bit             pop_pending;
    logic [MAXC-1:0] obs_tx, obs_en, obs_busy;
    logic [MAXC-1:0] exp_tx, exp_en, exp_busy;
    byte unsigned   exp_bytes[8];
    int             exp_n;

    function automatic logic frame_bit(input byte unsigned b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic fifo_drive();
        fifo_io    = (q.size() > 0) ? q[0] : 8'h00;
        fifo_empty = (q.size() == 0);
    endtask

    task automatic step();
        @(negedge clk);
        if (pop_pending && q.size() > 0) void'(q.pop_front());
        fifo_drive();
        pop_pending = fifo_en;
    endtask

    task automatic capture(input int n, input int drop_at);
        obs_tx = '0; obs_en = '0; obs_busy = '0;
        for (int i = 0; i < n; i++) begin
            obs_tx[i]   = tx;
            obs_en[i]   = fifo_en;
            obs_busy[i] = busy;
            if (i == drop_at) tx_enable = 1'b0;
            step();
        end
    endtask

    task automatic build_exp(input int n);
        int idx;
        exp_tx = '0; exp_en = '0; exp_busy = '0;
        for (int i = 0; i < n; i++) exp_tx[i] = 1'b1;
        idx = 1;
        for (int f = 0; f < exp_n; f++) begin
            exp_en[idx] = 1'b1;
            exp_busy[idx] = 1'b1;
            idx++;
            for (int k = 0; k < FB; k++) begin
                for (int c = 0; c < C; c++) begin
                    exp_tx[idx]   = frame_bit(exp_bytes[f], k);
                    exp_busy[idx] = 1'b1;
                    idx++;
                end
            end
        end
    endtask

    task automatic check_traces(input string tag);
        checks++;
        if (obs_tx !== exp_tx)
            $display("FAIL %s tx trace: got %h want %h", tag, obs_tx, exp_tx);
        else passed++;
        checks++;
        if (obs_en !== exp_en)
            $display("FAIL %s fifo_en trace: got %h want %h", tag, obs_en, exp_en);
        else passed++;
        checks++;
        if (obs_busy !== exp_busy)
            $display("FAIL %s busy trace: got %h want %h", tag, obs_busy, exp_busy);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_enable = 1'b0; q.delete(); fifo_drive(); pop_pending = 1'b0;
        repeat (3) step();
        checks++; if (tx !== 1'b1) $display("FAIL reset tx: got %b want 1", tx); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passed++;
        checks++; if (fifo_en !== 1'b0) $display("FAIL reset fifo_en: got %b want 0", fifo_en); else passed++;
        checks++; if (fifo_rw !== 1'b0) $display("FAIL reset fifo_rw: got %b want 0", fifo_rw); else passed++;
        reset = 1'b0; tx_enable = 1'b1;
        capture(100, -1);
        exp_n = 0;
        build_exp(100);
        check_traces("idle_empty");
    endtask

    task automatic test_single();
        int n;
        q.push_back(8'h55); exp_bytes[0] = 8'h55; exp_n = 1;
        fifo_drive(); tx_enable = 1'b1;
        n = 1 + FRAME + 8;
        capture(n, -1);
        build_exp(n);
        check_traces("single_55");
        checks++;
        if ($countones(obs_en) != 1)
            $display("FAIL single fifo_en pulses: got %0d want 1", $countones(obs_en));
        else passed++;
        checks++;
        if ($countones(obs_busy) != FRAME)
            $display("FAIL single busy length: got %0d want %0d", $countones(obs_busy), FRAME);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        q.push_back(8'hA3); q.push_back(8'h00); q.push_back(8'hFF);
        exp_bytes[0] = 8'hA3; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'hFF; exp_n = 3;
        fifo_drive(); tx_enable = 1'b1;
        n = 1 + 3 * FRAME + 10;
        capture(n, -1);
        build_exp(n);
        check_traces("b2b");
        checks++;
        if (q.size() != 0) $display("FAIL b2b fifo left: got %0d want 0", q.size());
        else passed++;
    endtask

    task automatic test_random();
        int n, k;
        for (int r = 0; r < 2; r++) begin
            k = $urandom_range(2, 4);
            for (int i = 0; i < k; i++) begin
                exp_bytes[i] = 8'($urandom);
                q.push_back(exp_bytes[i]);
            end
            exp_n = k;
            fifo_drive(); tx_enable = 1'b1;
            n = 1 + k * FRAME + 10;
            capture(n, -1);
            build_exp(n);
            check_traces("random");
        end
    endtask

    task automatic test_enable_drop();
        int n;
        q.push_back(8'h3C); q.push_back(8'h5A);
        exp_bytes[0] = 8'h3C; exp_n = 1;
        fifo_drive(); tx_enable = 1'b1;
        n = 1 + FRAME + 20;
        capture(n, 2 + 4 * C + 1);
        build_exp(n);
        check_traces("enable_drop");
        checks++;
        if (q.size() != 1) $display("FAIL enable_drop fifo left: got %0d want 1", q.size());
        else passed++;
        q.delete(); fifo_drive(); step();
    endtask

    task automatic test_reset_mid();
        int  n;
        bit  en_seen;
        q.push_back(8'h81); q.push_back(8'h42); q.push_back(8'h99);
        fifo_drive(); tx_enable = 1'b1;
        capture(2 + C + 3 * C, -1);
        reset = 1'b1;
        step();
        checks++; if (tx !== 1'b1) $display("FAIL reset_mid tx: got %b want 1", tx); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_mid busy: got %b want 0", busy); else passed++;
        en_seen = fifo_en;
        repeat (3) begin
            step();
            en_seen |= fifo_en;
        end
        checks++; if (en_seen !== 1'b0) $display("FAIL reset_mid fifo_en in reset: got %b want 0", en_seen); else passed++;
        checks++; if (q.size() != 2) $display("FAIL reset_mid fifo left: got %0d want 2", q.size()); else passed++;
        reset = 1'b0;
        exp_bytes[0] = 8'h42; exp_bytes[1] = 8'h99; exp_n = 2;
        n = 1 + 2 * FRAME + 10;
        capture(n, -1);
        build_exp(n);
        check_traces("after_reset");
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        int n, p0, p1;
        q.push_back(8'h01); q.push_back(8'h03);
        exp_bytes[0] = 8'h01; exp_bytes[1] = 8'h03; exp_n = 2;
        fifo_drive(); tx_enable = 1'b1;
        n = 1 + 2 * FRAME + 10;
        capture(n, -1);
        build_exp(n);
        check_traces("parity");
        p0 = 2 + 9 * C + C / 2;
        p1 = p0 + FRAME;
        checks++; if (obs_tx[p0] !== 1'b1) $display("FAIL parity 0x01: got %b want 1", obs_tx[p0]); else passed++;
        checks++; if (obs_tx[p1] !== 1'b0) $display("FAIL parity 0x03: got %b want 0", obs_tx[p1]); else passed++;
        checks++;
        if ($countones(obs_busy) / 2 - 1 != 44)
            $display("FAIL parity frame length: got %0d want 44", $countones(obs_busy) / 2 - 1);
        else passed++;
    endtask
`endif

    initial begin
        reset       = 1'b1;
        tx_enable   = 1'b0;
        fifo_io     = 8'h00;
        fifo_empty  = 1'b1;
        pop_pending = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_enable_drop();
        test_reset_mid();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
